// File: rtl/seq101_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seq101_pkg: state encoding and preamble constants for the 101-preamble link.
// Rev 1.0
// -----------------------------------------------------------------------------
package seq101_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_A = 3'd1,
    PRE_B = 3'd2,
    PRE_C = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5
  } state_t;

  localparam logic [2:0] PREAMBLE     = 3'b101;
  localparam int         PREAMBLE_LEN = 3;

endpackage
`default_nettype wire

// File: rtl/seq101_frame_tx_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seq101_frame_tx_if: word handshake plus serial frame outputs of the transmitter.
// Rev 1.0
// -----------------------------------------------------------------------------
interface seq101_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out;
  logic              out_active;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out, out_active, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out, out_active, done
  );
endinterface
`default_nettype wire

// File: rtl/seq101_frame_tx_piso_shreg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seq101_frame_tx_piso_shreg: parallel-in/serial-out register, MSB first.
// Rev 1.0
// -----------------------------------------------------------------------------
module seq101_frame_tx_piso_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sreg;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign msb = sreg[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/seq101_frame_tx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seq101_frame_tx: sends 1,0,1 preamble then a word MSB first; SEQ101_TX_PARITY_EN
// appends an even-parity bit. Rev 1.0
// -----------------------------------------------------------------------------
module seq101_frame_tx
  import seq101_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             areset,
  seq101_frame_tx_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             handshake;
  logic             last_bit;
  logic             sreg_msb;
  logic             out_n;
  logic             tx_bit;
  logic             active;
  logic             ready;
  logic             done_pulse;
  logic             parity_bit;

  assign handshake = bus.in_valid && ready;
  assign last_bit  = (cnt == '0);

  seq101_frame_tx_piso_shreg #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk    (clk),
    .areset (areset),
    .load   (handshake),
    .shift  (state_n == DATA),
    .din    (bus.in_data),
    .msb    (sreg_msb)
  );

`ifdef SEQ101_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      parity_q <= 1'b0;
    end else if (handshake) begin
      parity_q <= ^bus.in_data;
    end
  end

  assign parity_bit = parity_q;
`else
  assign parity_bit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (handshake) state_n = PRE_A;
      PRE_A: state_n = PRE_B;
      PRE_B: state_n = PRE_C;
      PRE_C: state_n = DATA;
      DATA: begin
        if (last_bit) begin
`ifdef SEQ101_TX_PARITY_EN
          state_n = PAR;
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    out_n = 1'b0;
    case (state_n)
      PRE_A:   out_n = PREAMBLE[2];
      PRE_B:   out_n = PREAMBLE[1];
      PRE_C:   out_n = PREAMBLE[0];
      DATA:    out_n = sreg_msb;
      PAR:     out_n = parity_bit;
      default: out_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_bit     <= 1'b0;
      active     <= 1'b0;
      ready      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      tx_bit     <= out_n;
      active     <= (state_n != IDLE);
      ready      <= (state_n == IDLE);
      done_pulse <= (state_n == IDLE) && (state != IDLE);
      if (handshake) begin
        cnt <= CNT_LOAD;
      end else if ((state == DATA) && !last_bit) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.out        = tx_bit;
  assign bus.out_active = active;
  assign bus.in_ready   = ready;
  assign bus.done       = done_pulse;

endmodule
`default_nettype wire
